fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage: PC register, 4-way next-PC select, IF/ID output register.
//  Talks to instruction memory over a req/ack handshake with variable latency; one request outstanding.
//  Supports stall, flush and redirect with discard of in-flight responses. Feeds the decode stage.
// PARAMETERS
//  XLEN     16      PC / address width
//  INSTR_W  16      instruction width
//  PC_STEP  2       sequential PC increment in bytes
//  RESET_PC 0       PC value loaded on reset
//  NOP      0       instruction word driven on if_instr when the output is not valid
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous active-high reset
//  pc_src      in   2        00 seq, 01 jump (j_target), 10 branch (b_target), 11 return (ret_addr)
//  j_target    in   XLEN     jump target
//  b_target    in   XLEN     branch target
//  ret_addr    in   XLEN     return address
//  stall       in   1        hold the IF/ID register and stop PC advance
//  flush       in   1        invalidate the IF/ID register next cycle
//  imem_req    out  1        fetch request; held high until imem_ack
//  imem_addr   out  XLEN     fetch address; stable while imem_req=1
//  imem_ack    in   1        response valid; may be in the same cycle as req
//  imem_rdata  in   INSTR_W  instruction, valid with imem_ack
//  if_valid    out  1        IF/ID register holds a real instruction
//  if_pc       out  XLEN     PC of if_instr
//  if_npc      out  XLEN     if_pc + PC_STEP, mod 2^XLEN
//  if_instr    out  INSTR_W  fetched instruction, NOP when if_valid=0
// BEHAVIOUR
//  Reset (sync, any state): PC=RESET_PC, state=FETCH, imem_req=1 next cycle with imem_addr=RESET_PC,
//   if_valid=0, if_pc=0, if_npc=0, if_instr=NOP, hold buffer empty.
//  redirect = (pc_src != 00). Priority: rst > redirect > flush > stall.
//  States:
//   FETCH: imem_req=1, imem_addr=PC.
//    ack & !stall -> IF/ID <= {1,PC,PC+STEP,rdata}; PC <= PC+STEP; stay in FETCH.
//    ack & stall  -> rdata/PC parked in 1-entry hold buffer; IF/ID unchanged; go to HOLD.
//   HOLD: imem_req=0. When stall=0: IF/ID <= buffer, PC <= PC+STEP, go to FETCH.
//   DRAIN: imem_req=1 at the old address until ack; the response is discarded.
//    Then go to FETCH at the redirected PC.
//  Redirect in any state:
//   PC <= selected target; if_valid <= 0; if_instr <= NOP; hold buffer cleared.
//   Request outstanding with no ack this cycle -> DRAIN, else -> FETCH.
//   Redirect overrides stall.
//  Flush without redirect:
//   if_valid <= 0, if_instr <= NOP; PC, hold buffer and state are unchanged.
//  Latency: ack at cycle t -> if_valid at t+1; next request at t+1.
//   A zero-wait memory sustains 1 instruction/cycle.
//  Arithmetic: PC+PC_STEP wraps mod 2^XLEN, no overflow flag.
//  pc_src is sampled every cycle; 00 with no ack leaves PC unchanged.
//  Never more than one request outstanding; imem_addr never changes while req=1 and ack=0.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0].
//   perf_fetched: +1 per instruction written valid into IF/ID.
//   perf_bubbles: +1 per cycle with if_valid=0 after reset.
//   Both clear on rst and wrap at 2^32.
//  FETCH_PERF_EN undefined: neither the ports nor the counters exist; all other behaviour is identical.
// TESTING
//  1 rst 2 cycles, zero-wait mem returning addr as data -> req addr 0 then 2,4,6; if_pc 0,2,4;
//    if_npc 2,4,6; if_valid from cycle after first ack.
//  2 3-cycle mem latency, pc_src=01 j_target=16'h0040 mid-wait -> old ack discarded (no valid out);
//    next req addr 16'h0040; first valid if_pc 16'h0040.
//  3 stall=1 for 4 cycles while ack arrives -> IF/ID frozen, req=0 in HOLD.
//    On release the held instr appears; no loss or duplication.
//  4 flush=1 one cycle -> if_valid=0, if_instr=NOP next cycle; fetch continues at next sequential PC.
//  5 RESET_PC=16'hFFFE, zero-wait -> if_pc FFFE, if_npc 0000; next req addr 0000.
//  6 FETCH_PERF_EN: 10 fetches, 1 flush, 3 stall cycles -> perf_fetched=10;
//    perf_bubbles counts invalid cycles; both zero after rst.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC select, imem req/ack fetch and IF/ID register.
// Optional FETCH_PERF_EN adds fetched-instruction and bubble counters.
module fetch_unit #(
  parameter int                 XLEN     = 16,
  parameter int                 INSTR_W  = 16,
  parameter int                 PC_STEP  = 2,
  parameter logic [XLEN-1:0]    RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP      = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_src,
  input  logic [XLEN-1:0]    j_target,
  input  logic [XLEN-1:0]    b_target,
  input  logic [XLEN-1:0]    ret_addr,
  input  logic               stall,
  input  logic               flush,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_npc,
  output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_t             state;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    pc_inc;
  logic [XLEN-1:0]    target;
  logic [INSTR_W-1:0] hold_instr;
  logic               redirect;
  logic               take;
  logic               hold_out;

  assign pc_inc   = pc + STEP;
  assign redirect = (pc_src != 2'b00);
  assign take     = (state == FETCH) && imem_ack && !stall;
  assign hold_out = (state == HOLD) && !stall;

  always_comb begin
    target = pc;
    unique case (pc_src)
      2'b01:   target = j_target;
      2'b10:   target = b_target;
      2'b11:   target = ret_addr;
      default: target = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      imem_req   <= 1'b1;
      imem_addr  <= RESET_PC;
      hold_instr <= NOP;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_npc     <= '0;
      if_instr   <= NOP;
    end else if (redirect) begin
      pc         <= target;
      hold_instr <= NOP;
      if_valid   <= 1'b0;
      if_instr   <= NOP;
      // an unanswered request keeps its address until the stale ack is drained
      if (imem_req && !imem_ack) begin
        state <= DRAIN;
      end else begin
        state     <= FETCH;
        imem_req  <= 1'b1;
        imem_addr <= target;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (take) begin
            if_valid  <= 1'b1;
            if_pc     <= pc;
            if_npc    <= pc_inc;
            if_instr  <= imem_rdata;
            pc        <= pc_inc;
            imem_addr <= pc_inc;
          end else if (imem_ack) begin
            hold_instr <= imem_rdata;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (hold_out) begin
            if_valid  <= 1'b1;
            if_pc     <= pc;
            if_npc    <= pc_inc;
            if_instr  <= hold_instr;
            pc        <= pc_inc;
            imem_req  <= 1'b1;
            imem_addr <= pc_inc;
            state     <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            imem_addr <= pc;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
      if (flush) begin
        if_valid <= 1'b0;
        if_instr <= NOP;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic wr_valid;

  assign wr_valid = (take || hold_out) && !flush && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (wr_valid) perf_fetched <= perf_fetched + 32'd1;
      if (!if_valid) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`else
  // counters are absent in this build
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against a transaction-level
// model of the fetch stream (pending-response queue, expected request address).
module tb_fetch_unit;

  localparam logic [15:0] NOPW = 16'h0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  pc_src;
  logic [15:0] j_target, b_target, ret_addr;
  logic        stall, flush;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_pc, if_npc, if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
  logic [31:0] pf2, pb2;
`endif

  logic        r2, v2;
  logic [15:0] a2, p2, n2, i2;
  logic        ack2;
  logic [15:0] rd2;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign ack2 = r2;
  assign rd2  = mem(a2);

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_src(pc_src),
    .j_target(j_target), .b_target(b_target), .ret_addr(ret_addr),
    .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_npc(if_npc), .if_instr(if_instr)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst), .pc_src(2'b00),
    .j_target(16'h0000), .b_target(16'h0000), .ret_addr(16'h0000),
    .stall(1'b0), .flush(1'b0),
    .imem_req(r2), .imem_addr(a2),
    .imem_ack(ack2), .imem_rdata(rd2),
    .if_valid(v2), .if_pc(p2), .if_npc(n2), .if_instr(i2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf2), .perf_bubbles(pb2)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } ent_t;

  ent_t        pend[$];
  bit          armed = 0;
  bit          mv;
  logic [15:0] mpc, mnpc, mins;
  logic [15:0] cur_addr, drain_tgt;
  bit          draining;
  logic [31:0] m_fetched, m_bubbles;
  bit          busy = 0;
  int          wait_left = 0;
  int          lat_mode = 0;

  task automatic cyc(input bit r, input logic [1:0] src,
                     input logic [15:0] tgt, input bit st, input bit fl);
    bit   exp_req;
    ent_t e;
    @(negedge clk);
    exp_req = (pend.size() == 0);
    if (armed) begin
      chk("req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) chk("addr", {16'd0, imem_addr}, {16'd0, cur_addr});
      chk("valid", {31'd0, if_valid}, {31'd0, mv});
      chk("instr", {16'd0, if_instr}, {16'd0, mins});
      if (mv) begin
        chk("pc", {16'd0, if_pc}, {16'd0, mpc});
        chk("npc", {16'd0, if_npc}, {16'd0, mnpc});
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    end
    rst      = r;
    pc_src   = src;
    j_target = 16'($urandom);
    b_target = 16'($urandom);
    ret_addr = 16'($urandom);
    case (src)
      2'b01:   j_target = tgt;
      2'b10:   b_target = tgt;
      2'b11:   ret_addr = tgt;
      default: ;
    endcase
    stall      = st;
    flush      = fl;
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    if (imem_req === 1'b1 && !busy) begin
      busy      = 1;
      wait_left = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
    end
    if (busy && imem_req === 1'b1) begin
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(imem_addr);
        busy       = 0;
      end else begin
        wait_left--;
      end
    end
    if (r) busy = 0;
    if (r) begin
      armed     = 1;
      pend.delete();
      mv        = 0;
      mpc       = 16'h0000;
      mnpc      = 16'h0000;
      mins      = NOPW;
      cur_addr  = 16'h0000;
      draining  = 0;
      m_fetched = 0;
      m_bubbles = 0;
    end else begin
      if (!mv) m_bubbles++;
      if (src != 2'b00) begin
        mv   = 0;
        mins = NOPW;
        pend.delete();
        if (exp_req && !imem_ack) begin
          draining  = 1;
          drain_tgt = tgt;
        end else begin
          draining = 0;
          cur_addr = tgt;
        end
      end else begin
        if (imem_ack) begin
          if (draining) begin
            draining = 0;
            cur_addr = drain_tgt;
          end else begin
            pend.push_back('{cur_addr, mem(cur_addr)});
          end
        end
        if (pend.size() > 0 && !st) begin
          e        = pend.pop_front();
          cur_addr = e.pc + 16'd2;
          if (!fl) begin
            mv   = 1;
            mpc  = e.pc;
            mnpc = e.pc + 16'd2;
            mins = e.ins;
            m_fetched++;
          end
        end
        if (fl) begin
          mv   = 0;
          mins = NOPW;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 16'h0000, 0, 0);
  endtask

  initial begin
    bit          seen;
    logic [1:0]  src;
    logic [15:0] tgt;
    int          pick;
    rst = 1'b1; pc_src = 2'b00; stall = 1'b0; flush = 1'b0;
    j_target = '0; b_target = '0; ret_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;

    // reset then zero-wait sequential stream
    lat_mode = 0;
    cyc(1, 2'b00, 16'h0000, 0, 0);
    cyc(1, 2'b00, 16'h0000, 0, 0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", {16'd0, imem_addr}, 32'h0000);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", {16'd0, if_pc}, 32'h0000);
    chk("rst_npc", {16'd0, if_npc}, 32'h0000);
    chk("rst_instr", {16'd0, if_instr}, {16'd0, NOPW});
`ifdef FETCH_PERF_EN
    chk("rst_perf_f", perf_fetched, 32'd0);
    chk("rst_perf_b", perf_bubbles, 32'd0);
`endif
    cyc(0, 2'b00, 16'h0000, 0, 0);
    chk("wrap_req_addr", {16'd0, a2}, 32'hFFFE);
    chk("wrap_valid0", {31'd0, v2}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 2'b00, 16'h0000, 0, 0);
      chk("t1_valid", {31'd0, if_valid}, 32'd1);
      chk("t1_pc", {16'd0, if_pc}, 32'(2 * k));
      chk("t1_npc", {16'd0, if_npc}, 32'(2 * k + 2));
      chk("t1_addr", {16'd0, imem_addr}, 32'(2 * k + 2));
      if (k == 0) begin
        chk("wrap_pc", {16'd0, p2}, 32'hFFFE);
        chk("wrap_npc", {16'd0, n2}, 32'h0000);
        chk("wrap_next_addr", {16'd0, a2}, 32'h0000);
        chk("wrap_instr", {16'd0, i2}, {16'd0, mem(16'hFFFE)});
      end
    end

    // jump while a 3-cycle request is in flight
    lat_mode = 3;
    cyc(0, 2'b00, 16'h0000, 0, 0);
    cyc(0, 2'b01, 16'h0040, 0, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(0, 2'b00, 16'h0000, 0, 0);
      if (if_valid === 1'b1) begin
        seen = 1;
        chk("t2_first_pc", {16'd0, if_pc}, 32'h0040);
      end
    end
    if (!seen) chk("t2_timeout", 32'd0, 32'd1);

    // stall across a response, then release
    lat_mode = 1;
    idle(2);
    for (int k = 0; k < 4; k++) cyc(0, 2'b00, 16'h0000, 1, 0);
    idle(6);

    // single-cycle flush with zero-wait memory
    lat_mode = 0;
    idle(2);
    cyc(0, 2'b00, 16'h0000, 0, 1);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) lat_mode = (lat_mode < 0) ? 0 : -1;
      src = 2'b00;
      if ($urandom_range(9, 0) == 0) src = 2'($urandom_range(3, 1));
      pick = int'($urandom_range(3, 0));
      tgt  = (pick == 0) ? 16'hFFFE :
             (pick == 1) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
      cyc($urandom_range(199, 0) == 0, src, tgt,
          $urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
